dac_cmd_sequencer: RTL



---
 rtl/lcb_cmd_pkg.sv | 31 +++
 rtl/dac_cmd_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/lcb_cmd_pkg.sv
// Shared command encoding for the per-channel DAC command sequencer:
// opcodes, DAC_WR field positions and sequencer state encoding.
package lcb_cmd_pkg;

    localparam logic [2:0] OP_NO_OP     = 3'd0;
    localparam logic [2:0] OP_CANCEL    = 3'd1;
    localparam logic [2:0] OP_WAIT_TRIG = 3'd2;
    localparam logic [2:0] OP_DAC_WR    = 3'd3;
    localparam logic [2:0] OP_DELAY     = 3'd4;

    localparam int TYPE_LSB   = 29;
    localparam int TYPE_MSB   = 31;
    localparam int VAL_LSB    = 0;
    localparam int VAL_MSB    = 28;
    localparam int VAL_W      = VAL_MSB - VAL_LSB + 1;

    localparam int SAMPLE_LSB = 0;
    localparam int SAMPLE_MSB = 15;
    localparam int HOLD_LSB   = 16;
    localparam int HOLD_MSB   = 28;
    localparam int HOLD_W     = HOLD_MSB - HOLD_LSB + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TRIG = 3'd1,
        S_DAC_WR    = 3'd2,
        S_DELAY     = 3'd3,
        S_ERROR     = 3'd4
    } state_t;

endpackage

// File: rtl/dac_cmd_sequencer.sv
// Per-channel DAC command sequencer: pops commands from an FWFT buffer and
// issues DAC sample words with timed holds and trigger waits.
module dac_cmd_sequencer
    import lcb_cmd_pkg::*;
#(
    parameter int                   DAC_WIDTH        = 16,
    parameter logic [DAC_WIDTH-1:0] INITIAL_DAC_WORD = 16'h8000
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic                 cmd_word_rd_en,
    input  logic [31:0]          cmd_word,
    input  logic                 cmd_buf_empty,
    input  logic                 trigger,
    output logic                 waiting_for_trigger,
    output logic [DAC_WIDTH-1:0] dac_word,
    output logic                 dac_valid,
    input  logic                 dac_ready,
    output logic                 bad_cmd,
    output logic                 unexpected_trig
);

    state_t               state, state_next;
    logic [VAL_W-1:0]     count, count_next;
    logic [DAC_WIDTH-1:0] word_next;
    logic                 valid_next;
    logic                 waiting_next;
    logic                 bad_next;
    logic                 unexp_next;
    logic [2:0]           cmd_type;
    logic [VAL_W-1:0]     cmd_val;
    logic                 rd_en;

    assign cmd_type = cmd_word[TYPE_MSB:TYPE_LSB];
    assign cmd_val  = cmd_word[VAL_MSB:VAL_LSB];

    // CANCEL is the only opcode allowed to pre-empt a busy state.
    assign rd_en = !cmd_buf_empty && (state != S_ERROR) &&
                   ((state == S_IDLE) || (cmd_type == OP_CANCEL));
    assign cmd_word_rd_en = rd_en;

    always_comb begin
        state_next = state;
        count_next = count;
        word_next  = dac_word;
        valid_next = dac_valid;
        bad_next   = bad_cmd;
        unexp_next = unexpected_trig || (trigger && (state != S_WAIT_TRIG));

        if (rd_en && (cmd_type == OP_CANCEL) && (state != S_IDLE)) begin
            state_next = S_IDLE;
            valid_next = 1'b0;
            count_next = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (rd_en) begin
                        case (cmd_type)
                            OP_NO_OP, OP_CANCEL: begin
                                state_next = S_IDLE;
                            end
                            OP_WAIT_TRIG: begin
                                state_next = S_WAIT_TRIG;
                            end
                            OP_DAC_WR: begin
                                // Hold is parked in the counter until the word is accepted.
                                word_next  = cmd_word[SAMPLE_MSB:SAMPLE_LSB];
                                valid_next = 1'b1;
                                count_next = VAL_W'(cmd_word[HOLD_MSB:HOLD_LSB]);
                                state_next = S_DAC_WR;
                            end
                            OP_DELAY: begin
                                if (cmd_val != '0) begin
                                    count_next = cmd_val;
                                    state_next = S_DELAY;
                                end
                            end
                            default: begin
                                bad_next   = 1'b1;
                                state_next = S_ERROR;
                            end
                        endcase
                    end
                end
                S_WAIT_TRIG: begin
                    if (trigger) begin
                        state_next = S_IDLE;
                    end
                end
                S_DAC_WR: begin
                    if (dac_ready) begin
                        valid_next = 1'b0;
                        state_next = (count == '0) ? S_IDLE : S_DELAY;
                    end
                end
                S_DELAY: begin
                    count_next = count - VAL_W'(1);
                    if (count == VAL_W'(1)) begin
                        state_next = S_IDLE;
                    end
                end
                S_ERROR: begin
                    valid_next = 1'b0;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        waiting_next = (state_next == S_WAIT_TRIG);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state               <= S_IDLE;
            count               <= '0;
            dac_word            <= INITIAL_DAC_WORD;
            dac_valid           <= 1'b0;
            waiting_for_trigger <= 1'b0;
            bad_cmd             <= 1'b0;
            unexpected_trig     <= 1'b0;
        end else begin
            state               <= state_next;
            count               <= count_next;
            dac_word            <= word_next;
            dac_valid           <= valid_next;
            waiting_for_trigger <= waiting_next;
            bad_cmd             <= bad_next;
            unexpected_trig     <= unexp_next;
        end
    end

endmodule
